// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper and its requester plus the gate under test.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic       gate_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic       match;

  modport master (
    output start, abort, gate_out,
    input  in1, in2, in3, busy, done, truth_table, match
  );

  modport slave (
    input  start, abort, gate_out,
    output in1, in2, in3, busy, done, truth_table, match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all eight input patterns, majority-votes three samples
// per pattern and compares the captured truth table against an expected rule code.
//
// state  | meaning
// IDLE   | waiting for start; gate inputs parked at 000
// DRIVE  | current pattern applied, settle counter running
// SAMPLE | three consecutive samples of gate_out being voted
module truth_table_sweeper #(
  parameter int         SETTLE   = 16,
  parameter logic [7:0] EXPECTED = 8'h50
) (
  input logic                   clk,
  input logic                   reset,
  truth_table_sweeper_if.slave  bus
);

  localparam int              CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t      state;
  logic [2:0]  p;
  logic [CW-1:0] cnt;
  logic [1:0]  scnt;
  logic [1:0]  vote;
  logic [7:0]  wtab;
  logic        busy;
  logic        done;
  logic [7:0]  tt_word;
  logic        match;

  logic [2:0]  vsum;
  logic        maj;
  logic [2:0]  idx;
  logic [7:0]  final_tab;

  // Table bit index is {in3,in2,in1}, i.e. the pattern bit-reversed.
  always_comb begin
    vsum           = {1'b0, vote} + {2'b00, bus.gate_out};
    maj            = (vsum >= 3'd2);
    idx            = {p[0], p[1], p[2]};
    final_tab      = wtab;
    final_tab[idx] = maj;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      p       <= '0;
      cnt     <= '0;
      scnt    <= '0;
      vote    <= '0;
      wtab    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tt_word <= '0;
      match   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= DRIVE;
            p     <= '0;
            cnt   <= '0;
            wtab  <= '0;
            busy  <= 1'b1;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            p     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= SAMPLE;
              scnt  <= '0;
              vote  <= '0;
            end
          end
        end
        SAMPLE: begin
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            p     <= '0;
          end else if (scnt == 2'd2) begin
            wtab <= final_tab;
            if (p != 3'd7) begin
              p     <= p + 1'b1;
              cnt   <= '0;
              state <= DRIVE;
            end else begin
              tt_word <= final_tab;
              match   <= (final_tab == EXPECTED);
              done    <= 1'b1;
              busy    <= 1'b0;
              p       <= '0;
              state   <= IDLE;
            end
          end else begin
            vote <= vote + {1'b0, bus.gate_out};
            scnt <= scnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pattern register drives the gate directly, in1 being the MSB.
  assign bus.in1         = p[2];
  assign bus.in2         = p[1];
  assign bus.in3         = p[0];
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.truth_table = tt_word;
  assign bus.match       = match;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage wrapped around a single 3-input combinational logic gate (e.g. the 0x50 gate). It drives the gate's three inputs through all eight combinations, holds each pattern for a programmable settling time, and majority-votes three consecutive samples of the gate output. It assembles the results into an 8-bit truth-table word and compares it against an expected rule code. It is upstream of the gate, because it feeds in1..in3, and downstream of it, because it consumes the gate output.

## Interface
- SETTLE, 16: cycles each pattern is held before sampling begins; legal range is 1 or more.
- EXPECTED, 8'h50: rule code the captured table is compared against.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- abort  input  1  cancel an in-progress sweep.
- gate_out  input  1  output of the gate under sweep.
- in1, in2, in3  output  1 each  drive to the gate inputs.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table  output  8  last completed truth table; bit index is {in3,in2,in1}.
- match  output  1  table == EXPECTED for the last completed sweep.

## Operation
- State machine states are IDLE, DRIVE and SAMPLE.
- Internal registers:
  - pattern p, 3 bits.
  - settle counter cnt, width $clog2(SETTLE+1).
  - sample counter scnt, 2 bits.
  - vote count, 2 bits.
  - working table wtab, 8 bits.
- Input drive: {in1,in2,in3} = p, so in1 is the MSB. The inputs are registered outputs.
- IDLE, with start=1 at a clock edge: go to DRIVE. Set p←0, cnt←0, wtab←0, busy←1. The inputs are 000.
- DRIVE: cnt increments every cycle. When cnt==SETTLE-1, go to SAMPLE with scnt←0 and vote←0. DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE: on each of 3 edges, vote←vote+gate_out. On the 3rd edge, the majority bit (vote+gate_out ≥ 2) is written to wtab[{p[0],p[1],p[2]}], which is index {in3,in2,in1}.
  - If p≠7: p←p+1, cnt←0, go to DRIVE. The new pattern appears on the inputs at this same edge.
  - If p==7: table←final wtab, match←(final wtab==EXPECTED), done←1 for one cycle, busy←0, inputs←000, go to IDLE.
- With this bit ordering, a rule-0x50 gate (output 1 only for {in1,in2,in3} = 001 and 011) yields table=8'h50.
- start is ignored while busy=1.
- abort=1 in DRIVE or SAMPLE: next edge goes to IDLE with busy←0 and inputs←000. No done pulse; table and match are unchanged. abort in IDLE has no effect.
- abort and start both high in IDLE: abort has no effect, so start is accepted.
- Arithmetic: the counters never wrap within a sweep. p wraps from 7 only via IDLE.

## Timing
- Reset, as a synchronous edge with reset=1: IDLE; in1=in2=in3=0; busy=0; done=0; table=8'h00; match=0; all counters 0. Reset takes priority over start and abort, including mid-sweep.
- Per-pattern period is SETTLE+3 cycles: SETTLE cycles in DRIVE, then 3 in SAMPLE.
- Start to done: start is sampled at edge E0. busy is high from E0. done is high in the cycle after edge E0+8·(SETTLE+3).
- table and match update on the same edge that raises done, and hold until the next completed sweep.
- start held high continuously gives back-to-back sweeps, with one IDLE cycle between them (the done cycle). The done period is 8·(SETTLE+3)+1 cycles.
- The gate is sampled no earlier than SETTLE cycles after its inputs change. The upstream gate's combinational path must settle within SETTLE cycles.

## Test plan
- All scenarios use SETTLE=4 and a behavioral rule-0x50 gate.
  - Basic sweep: start pulse at E0 → done in the cycle after E0+56, table=8'h50, match=1, busy low again.
  - Wrong gate: tie gate_out=1 → table=8'hFF, match=0.
  - Glitch rejection: invert gate_out for exactly one cycle inside each SAMPLE window → table=8'h50 still, match=1. Invert it for two cycles in the p=1 window → table=8'h40, match=0.
  - Abort: assert abort while p=3 → busy=0 and inputs=000 after the next edge, no done pulse, table keeps its prior 8'h50. A fresh start then completes with table=8'h50.
  - Continuous start: start high for 200 cycles → done pulses 57 cycles apart.
  - Reset mid-sweep: assert reset while p=5 → next cycle all outputs are 0, including table=8'h00 and match=0. A subsequent start performs a full sweep normally.
